// File: rtl/config_frame_receiver_pkg.sv
// Shared types and constants for the configuration frame receiver.
// CONFIG_RX_CHECKSUM_EN adds the CHECK state that consumes a trailing XOR checksum word.
package config_frame_receiver_pkg;

    localparam logic [31:0] SYNC_WORD  = 32'hFAB0_FAB1;
    localparam logic [7:0]  END_COLUMN = 8'hFF;

    localparam int COL_MSB   = 31;
    localparam int COL_LSB   = 24;
    localparam int FRAME_MSB = 23;
    localparam int FRAME_LSB = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADDR  = 2'd1,
`ifdef CONFIG_RX_CHECKSUM_EN
        ST_DATA  = 2'd2,
        ST_CHECK = 2'd3
`else
        ST_DATA  = 2'd2
`endif
    } state_e;

    function automatic logic addr_in_range(input logic [7:0] col, input logic [7:0] frame,
                                           input int n_cols, input int n_frames);
        return (32'(col) < n_cols) && (32'(frame) < n_frames);
    endfunction

endpackage

// File: rtl/config_frame_select_decode.sv
// Turns a committed column/frame address into a registered one-hot frame select plus strobe.
module config_frame_select_decode
    import config_frame_receiver_pkg::*;
#(
    parameter int NumberOfCols    = 13,
    parameter int MaxFramesPerCol = 20
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    commit_i,
    input  logic [7:0]                              col_i,
    input  logic [7:0]                              frame_i,
    output logic [NumberOfCols*MaxFramesPerCol-1:0] frame_select_o,
    output logic                                    frame_strobe_o
);

    localparam int SEL_W = NumberOfCols * MaxFramesPerCol;

    logic [SEL_W-1:0] select_d, select_q;
    logic             strobe_d, strobe_q;
    int               sel_idx_s;

    // Out-of-range addresses never reach the fabric, even if a commit is requested
    always_comb begin
        sel_idx_s = 32'(col_i) * MaxFramesPerCol + 32'(frame_i);
        strobe_d  = commit_i && addr_in_range(col_i, frame_i, NumberOfCols, MaxFramesPerCol);
        select_d  = '0;
        for (int i = 0; i < SEL_W; i++) begin
            select_d[i] = strobe_d && (sel_idx_s == i);
        end
    end

    // Select and strobe registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            select_q <= '0;
            strobe_q <= 1'b0;
        end else begin
            select_q <= select_d;
            strobe_q <= strobe_d;
        end
    end

    assign frame_select_o = select_q;
    assign frame_strobe_o = strobe_q;

endmodule

// File: rtl/config_frame_receiver.sv
// Configuration word stream receiver: sync detection, frame address decode, row gathering, commit.
// Define CONFIG_RX_CHECKSUM_EN to check a trailing XOR checksum word after the end marker.
module config_frame_receiver
    import config_frame_receiver_pkg::*;
#(
    parameter int NumberOfRows    = 12,
    parameter int NumberOfCols    = 13,
    parameter int FrameBitsPerRow = 32,
    parameter int MaxFramesPerCol = 20
) (
    input  logic                                    CLK,
    input  logic                                    RESET,
    input  logic                                    SelfWriteStrobe,
    input  logic [FrameBitsPerRow-1:0]              SelfWriteData,
    output logic [NumberOfRows*FrameBitsPerRow-1:0] FrameData,
    output logic [NumberOfCols*MaxFramesPerCol-1:0] FrameSelect,
    output logic                                    FrameStrobe,
    output logic                                    ConfigActive,
    output logic                                    ConfigDone,
    output logic                                    AddrError,
    output logic                                    ChecksumError
);

    localparam int ROW_W  = $clog2(NumberOfRows);
    localparam int DATA_W = NumberOfRows * FrameBitsPerRow;

    state_e                state_d, state_q;
    logic [ROW_W-1:0]      row_d, row_q;
    logic [7:0]            col_d, col_q;
    logic [7:0]            frame_d, frame_q;
    logic                  suppress_d, suppress_q;
    logic [DATA_W-1:0]     frame_data_d, frame_data_q;
    logic                  active_d, active_q;
    logic                  done_d, done_q;
    logic                  addr_err_d, addr_err_q;
    logic                  commit_s;
    logic                  in_range_s;
    logic [7:0]            word_col_s;
    logic [7:0]            word_frame_s;
`ifdef CONFIG_RX_CHECKSUM_EN
    logic [FrameBitsPerRow-1:0] xor_d, xor_q;
    logic                       cks_err_d, cks_err_q;
`endif

    assign word_col_s   = SelfWriteData[COL_MSB:COL_LSB];
    assign word_frame_s = SelfWriteData[FRAME_MSB:FRAME_LSB];
    assign in_range_s   = addr_in_range(word_col_s, word_frame_s, NumberOfCols, MaxFramesPerCol);

    // Next-state and status logic; nothing moves on cycles without a strobed word
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        frame_d      = frame_q;
        suppress_d   = suppress_q;
        frame_data_d = frame_data_q;
        active_d     = active_q;
        done_d       = done_q;
        addr_err_d   = addr_err_q;
        commit_s     = 1'b0;
`ifdef CONFIG_RX_CHECKSUM_EN
        cks_err_d    = cks_err_q;
`endif
        if (SelfWriteStrobe) begin
            case (state_q)
                ST_IDLE: begin
                    if (SelfWriteData == SYNC_WORD) begin
                        state_d    = ST_ADDR;
                        active_d   = 1'b1;
                        done_d     = 1'b0;
                        addr_err_d = 1'b0;
                        row_d      = '0;
`ifdef CONFIG_RX_CHECKSUM_EN
                        cks_err_d  = 1'b0;
`endif
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ADDR: begin
                    if (SelfWriteData == SYNC_WORD) begin
                        addr_err_d = 1'b0;
                        row_d      = '0;
`ifdef CONFIG_RX_CHECKSUM_EN
                        cks_err_d  = 1'b0;
`endif
                    end else if (word_col_s == END_COLUMN) begin
                        active_d = 1'b0;
`ifdef CONFIG_RX_CHECKSUM_EN
                        state_d  = ST_CHECK;
`else
                        state_d  = ST_IDLE;
                        done_d   = 1'b1;
`endif
                    end else begin
                        col_d      = word_col_s;
                        frame_d    = word_frame_s;
                        suppress_d = !in_range_s;
                        addr_err_d = addr_err_q | !in_range_s;
                        row_d      = '0;
                        state_d    = ST_DATA;
                    end
                end
                ST_DATA: begin
                    // Word k lands in slice NumberOfRows-1-k, so the first word ends up on top
                    for (int r = 0; r < NumberOfRows; r++) begin
                        frame_data_d[FrameBitsPerRow*(NumberOfRows-1-r) +: FrameBitsPerRow] =
                            (row_q == ROW_W'(r)) ? SelfWriteData
                                                 : frame_data_q[FrameBitsPerRow*(NumberOfRows-1-r) +: FrameBitsPerRow];
                    end
                    if (row_q == ROW_W'(NumberOfRows - 1)) begin
                        row_d    = '0;
                        state_d  = ST_ADDR;
                        commit_s = !suppress_q;
                    end else begin
                        row_d = row_q + ROW_W'(1);
                    end
                end
`ifdef CONFIG_RX_CHECKSUM_EN
                ST_CHECK: begin
                    cks_err_d = cks_err_q | (SelfWriteData != xor_q);
                    done_d    = 1'b1;
                    state_d   = ST_IDLE;
                end
`endif
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

`ifdef CONFIG_RX_CHECKSUM_EN
    // Running XOR restarts at each sync and covers address, data and end-marker words
    always_comb begin
        xor_d = xor_q;
        if (SelfWriteStrobe && (SelfWriteData == SYNC_WORD) &&
            ((state_q == ST_IDLE) || (state_q == ST_ADDR))) begin
            xor_d = '0;
        end else if (SelfWriteStrobe && ((state_q == ST_ADDR) || (state_q == ST_DATA))) begin
            xor_d = xor_q ^ SelfWriteData;
        end else begin
            xor_d = xor_q;
        end
    end

    // Checksum state registers
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            xor_q     <= '0;
            cks_err_q <= 1'b0;
        end else begin
            xor_q     <= xor_d;
            cks_err_q <= cks_err_d;
        end
    end

    assign ChecksumError = cks_err_q;
`else
    assign ChecksumError = 1'b0;
`endif

    // Receiver state registers
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= ST_IDLE;
            row_q        <= '0;
            col_q        <= 8'd0;
            frame_q      <= 8'd0;
            suppress_q   <= 1'b0;
            frame_data_q <= '0;
            active_q     <= 1'b0;
            done_q       <= 1'b0;
            addr_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            frame_q      <= frame_d;
            suppress_q   <= suppress_d;
            frame_data_q <= frame_data_d;
            active_q     <= active_d;
            done_q       <= done_d;
            addr_err_q   <= addr_err_d;
        end
    end

    config_frame_select_decode #(
        .NumberOfCols    (NumberOfCols),
        .MaxFramesPerCol (MaxFramesPerCol)
    ) u_select_decode (
        .clk            (CLK),
        .rst            (RESET),
        .commit_i       (commit_s),
        .col_i          (col_q),
        .frame_i        (frame_q),
        .frame_select_o (FrameSelect),
        .frame_strobe_o (FrameStrobe)
    );

    assign FrameData    = frame_data_q;
    assign ConfigActive = active_q;
    assign ConfigDone   = done_q;
    assign AddrError    = addr_err_q;

endmodule

// File: tb/tb_config_frame_receiver.sv
// Scoreboard bench for config_frame_receiver: expected commits are queued by the stimulus
// and popped by a monitor whenever FrameStrobe is seen.
module tb_config_frame_receiver;

    localparam int ROWS = 12;
    localparam int COLS = 13;
    localparam int FB   = 32;
    localparam int MF   = 20;
    localparam int SELW = COLS * MF;
    localparam int DW   = ROWS * FB;
    localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

    logic            CLK = 1'b0;
    logic            RESET;
    logic            SelfWriteStrobe;
    logic [FB-1:0]   SelfWriteData;
    logic [DW-1:0]   FrameData;
    logic [SELW-1:0] FrameSelect;
    logic            FrameStrobe;
    logic            ConfigActive;
    logic            ConfigDone;
    logic            AddrError;
    logic            ChecksumError;

    typedef struct packed {
        logic [SELW-1:0] sel;
        logic [DW-1:0]   data;
    } exp_t;

    exp_t        exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] cs       = 32'd0;

    config_frame_receiver dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .SelfWriteStrobe (SelfWriteStrobe),
        .SelfWriteData   (SelfWriteData),
        .FrameData       (FrameData),
        .FrameSelect     (FrameSelect),
        .FrameStrobe     (FrameStrobe),
        .ConfigActive    (ConfigActive),
        .ConfigDone      (ConfigDone),
        .AddrError       (AddrError),
        .ChecksumError   (ChecksumError)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every strobe must match the oldest queued commit; select must be 0 otherwise
    always @(negedge CLK) begin
        exp_t e;
        if (RESET === 1'b0) begin
            if (FrameStrobe === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_strobe actual=1 required=0 at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("frame_select", DW'(FrameSelect), DW'(e.sel));
                    check("frame_data", FrameData, e.data);
                end
            end else begin
                check("select_idle", DW'(FrameSelect), '0);
            end
        end
    end

    task automatic send(input logic [31:0] w);
        SelfWriteStrobe = 1'b1;
        SelfWriteData   = w;
        if (w == SYNC) cs = 32'd0;
        else           cs = cs ^ w;
        @(posedge CLK);
        #1;
        SelfWriteStrobe = 1'b0;
        SelfWriteData   = 32'd0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // One address word plus ROWS data words base+0..base+ROWS-1, gap idle cycles after each
    task automatic frame(input logic [31:0] addr, input logic [31:0] base, input int gap,
                         input bit expect_commit);
        exp_t e;
        int   idx;
        idx = int'(addr[31:24]) * MF + int'(addr[23:16]);
        e.data = '0;
        for (int i = 0; i < SELW; i++) e.sel[i] = (i == idx);
        send(addr);
        if (gap > 0) idle(gap);
        for (int k = 0; k < ROWS; k++) begin
            e.data[FB*(ROWS-1-k) +: FB] = base + 32'(k);
            if (k == ROWS - 1 && expect_commit) exp_q.push_back(e);
            send(base + 32'(k));
            if (k == ROWS - 1) check("strobe_latency", DW'(FrameStrobe), DW'(expect_commit));
            if (gap > 0) idle(gap);
        end
    endtask

    initial begin
        RESET           = 1'b1;
        SelfWriteStrobe = 1'b0;
        SelfWriteData   = 32'd0;
        idle(3);
        check("rst_frame_data", FrameData, '0);
        check("rst_select", DW'(FrameSelect), '0);
        check("rst_status", DW'({FrameStrobe, ConfigActive, ConfigDone, AddrError, ChecksumError}), '0);
        RESET = 1'b0;
        idle(2);

        // Junk before sync is ignored
        send(32'hFFFF_FFFF);
        send(32'h0000_0000);
        check("pre_sync_active", DW'(ConfigActive), '0);
        send(SYNC);
        check("sync_active", DW'(ConfigActive), DW'(1'b1));
        check("sync_done", DW'(ConfigDone), '0);

        // Column 2 frame 3 -> select bit 43, full rate then strobe every 10th cycle
        frame(32'h0203_0000, 32'h1, 0, 1'b1);
        frame(32'h0203_0000, 32'h1, 9, 1'b1);
        check("no_addr_err", DW'(AddrError), '0);

        // Column 13 is out of range: flagged, no commit; next valid frame commits
        frame(32'h0D00_0000, 32'h100, 0, 1'b0);
        check("addr_err_col", DW'(AddrError), DW'(1'b1));
        frame(32'h0C13_0000, 32'hA500_0000, 0, 1'b1);
        frame(32'h0000_0000, 32'h5A00_0010, 2, 1'b1);
        check("addr_err_sticky", DW'(AddrError), DW'(1'b1));
        send(SYNC);
        check("resync_clears_err", DW'(AddrError), '0);
        frame(32'h0014_0000, 32'h200, 0, 1'b0);
        check("addr_err_frame", DW'(AddrError), DW'(1'b1));

        // End marker
        send(32'hFF00_0000);
        check("end_active", DW'(ConfigActive), '0);
`ifdef CONFIG_RX_CHECKSUM_EN
        check("end_done_pending", DW'(ConfigDone), '0);
        send(cs);
        check("cks_ok_err", DW'(ChecksumError), '0);
`endif
        check("end_done", DW'(ConfigDone), DW'(1'b1));
        idle(2);
        check("done_holds", DW'(ConfigDone), DW'(1'b1));

        // Reset mid-frame discards the partial frame and returns to IDLE
        send(SYNC);
        check("resync_done_clear", DW'(ConfigDone), '0);
        send(32'h0101_0000);
        for (int k = 0; k < 5; k++) send(32'h300 + 32'(k));
        RESET = 1'b1;
        #1;
        check("midrst_frame_data", FrameData, '0);
        check("midrst_status", DW'({FrameStrobe, ConfigActive, ConfigDone, AddrError, ChecksumError}), '0);
        idle(1);
        RESET = 1'b0;
        idle(1);
        send(32'h0101_0000);
        check("post_rst_needs_sync", DW'(ConfigActive), '0);
        send(SYNC);
        frame(32'h0101_0000, 32'h4000_0000, 0, 1'b1);

`ifdef CONFIG_RX_CHECKSUM_EN
        send(32'hFF00_0000);
        send(cs ^ 32'h0000_0001);
        check("cks_bad_err", DW'(ChecksumError), DW'(1'b1));
        check("cks_bad_done", DW'(ConfigDone), DW'(1'b1));
`endif

        idle(4);
        check("all_commits_seen", DW'(exp_q.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
